dut_access_arbiter: RTL and testbench
=====================================

// Module: dut_access_arbiter
// PURPOSE
//  Shares the dut register-access ports (write/read method pairs, 3-bit address, 1-bit data) between NUM_REQ requesters.
//  Round-robin grant, one transaction in flight, en driven only while the matching rdy is high, one response pulse per transaction.
//  Sits between the bench or system masters and the dut instance, in the same clock domain.
// PARAMETERS
//  NUM_REQ     2    number of requesters, 2..8
//  TIMEOUT     15   max ISSUE cycles waiting on rdy before abort (used only with ARB_TIMEOUT_EN)
// PORTS
//  CLK            in   1          single clock, rising edge
//  RST_N          in   1          asynchronous, active-low reset
//  req_valid      in   NUM_REQ    requester i has a transaction
//  req_write      in   NUM_REQ    1=write, 0=read
//  req_addr       in   3*NUM_REQ  register address, requester i at [3i+2:3i]
//  req_wdata      in   NUM_REQ    write data bit
//  req_ready      out  NUM_REQ    one-hot accept; transfer when valid&ready
//  rsp_valid      out  NUM_REQ    one-cycle completion pulse to owner
//  rsp_data       out  1          read data (0 for writes), valid with rsp_valid
//  rsp_err        out  1          timeout abort flag, valid with rsp_valid (tied 0 without macro)
//  write_address  out  3          to dut
//  write_data     out  1          to dut
//  write_en       out  1          to dut
//  write_rdy      in   1          from dut
//  read_address   out  3          to dut
//  read_en        out  1          to dut
//  read_data      in   1          from dut, valid in the read_en cycle
//  read_rdy       in   1          from dut
// BEHAVIOUR
//  - Reset: state=IDLE, rr pointer=0, all outputs 0 (req_ready, rsp_*, *_en, *_address, *_data).
//  - FSM IDLE -> ISSUE -> RESP -> IDLE.
//  - IDLE: req_ready is combinational; it is one-hot to the first valid requester at or after the pointer, circular.
//    On accept, the op, addr, wdata and owner id are latched, the pointer becomes owner+1 mod NUM_REQ, and the FSM goes to ISSUE.
//  - ISSUE: the latched address drives write_address or read_address; the other address is held at 0.
//    write_en = is_write & write_rdy; read_en = !is_write & read_rdy (combinational from rdy, never while rdy low).
//    On the fire cycle, read_data is registered and the FSM goes to RESP. If rdy is low, the FSM stays in ISSUE indefinitely.
//  - RESP: rsp_valid[owner]=1 for exactly one cycle with rsp_data and rsp_err, then IDLE.
//    req_ready=0 in ISSUE and RESP.
//  - Best-case latency: accept at T, en at T+1, rsp_valid at T+2, next accept at T+3.
//  - Requester inputs are ignored outside the accept cycle. Changing req_* after accept has no effect.
//  - Async reset mid-transaction: *_en drops immediately, the in-flight transaction is discarded, and no rsp is issued.
//  - Out-of-range addresses (6,7) pass through unchanged; decode belongs to the dut.
// CONFIGURATION
//  - ARB_TIMEOUT_EN defined: a cycle counter clears on ISSUE entry and increments each ISSUE cycle with rdy low.
//    If it reaches TIMEOUT, the transaction is aborted: no en, go to RESP with rsp_err=1 and rsp_data=0.
//  - ARB_TIMEOUT_EN undefined: no counter, rsp_err tied 0, ISSUE waits forever.
// STRUCTURE
//  - Package dut_if_pkg: ADDR_W=3, DATA_W=1, state enum {IDLE,ISSUE,RESP}, op encoding (OP_READ=0, OP_WRITE=1).
//  - Sub-module rr_arbiter #(N): inputs req vector and pointer; output one-hot grant and encoded index; purely combinational.
//  - The FSM, latches, timeout counter and dut port drive are in dut_access_arbiter.
// TESTING
//  1. Reset with all inputs idle, then release: all outputs 0, and after 5 cycles req_ready stays 0 with no req_valid.
//  2. Req0 write addr=2, wdata=1, write_rdy=1 at accept T: write_en=1 with addr 2 and data 1 at T+1; rsp_valid[0] at T+2 with rsp_data=0.
//  3. Req1 read addr=3, read_rdy=1, read_data=1: read_en at T+1; rsp_valid[1] at T+2 with rsp_data=1.
//  4. Both requesters valid continuously with rdy high: grants alternate 0,1,0,1 every 3 cycles with no starvation.
//  5. Write with write_rdy held low for 6 cycles, then high: write_en only on the first rdy-high cycle; with the macro and TIMEOUT=15, no error.
//  6. ARB_TIMEOUT_EN, read_rdy stuck 0: rsp_err=1 after 15 ISSUE cycles with no read_en; RST_N pulsed mid-ISSUE clears read_en and gives no rsp.

Source files
------------

// File: rtl/dut_if_pkg.sv
// Shared types for the dut register-access ports: widths, arbiter FSM states
// and the write/read op encoding.
package dut_if_pkg;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DATA_W = 1;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
   typedef enum logic {OP_READ = 1'b0, OP_WRITE = 1'b1} op_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant and index of the first
// asserted request at or after ptr, searching circularly.
module rr_arbiter #(
   parameter int unsigned N = 2,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx
);

   always_comb begin
      logic [IW-1:0] j;
      logic          found;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = '0;
      for (int unsigned i = 0; i < N; i++) begin
         j = IW'((32'(ptr) + i) % N);
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = j;
         end
      end
   end

endmodule

// File: rtl/dut_access_arbiter.sv
// Shares the dut write/read register ports between NUM_REQ requesters, one
// transaction at a time. Optional rdy timeout abort under `ARB_TIMEOUT_EN.
module dut_access_arbiter
   import dut_if_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
   input  logic [NUM_REQ-1:0]        req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_err,
   output logic [ADDR_W-1:0]         write_address,
   output logic [DATA_W-1:0]         write_data,
   output logic                      write_en,
   input  logic                      write_rdy,
   output logic [ADDR_W-1:0]         read_address,
   output logic                      read_en,
   input  logic [DATA_W-1:0]         read_data,
   input  logic                      read_rdy
);

   localparam int unsigned IW = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
      $error("dut_access_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
   end

   state_e             state;
   op_e                op;
   logic [IW-1:0]      ptr;
   logic [IW-1:0]      owner;
   logic [NUM_REQ-1:0] grant;
   logic [IW-1:0]      grant_idx;
   logic               accept;
   logic               fire;
   logic               done;
   logic [ADDR_W-1:0]  sel_addr;
   logic               sel_write;
   logic [DATA_W-1:0]  sel_wdata;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (grant_idx)
   );

   assign req_ready = (state == IDLE) ? grant : '0;
   assign accept    = |(req_valid & req_ready);

   // en follows rdy combinationally so it can never be high while rdy is low
   assign write_en = (state == ISSUE) && (op == OP_WRITE) && write_rdy;
   assign read_en  = (state == ISSUE) && (op == OP_READ)  && read_rdy;
   assign fire     = write_en || read_en;

   always_comb begin
      sel_addr  = '0;
      sel_write = 1'b0;
      sel_wdata = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_write = req_write[i];
            sel_wdata = req_wdata[i];
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] to_cnt;
   logic             abort;
   assign abort = (state == ISSUE) && !fire && (to_cnt == CNT_W'(TIMEOUT - 1));
   assign done  = fire || abort;
`else
   assign done    = fire;
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state         <= IDLE;
         op            <= OP_READ;
         ptr           <= '0;
         owner         <= '0;
         write_address <= '0;
         write_data    <= '0;
         read_address  <= '0;
         rsp_valid     <= '0;
         rsp_data      <= '0;
`ifdef ARB_TIMEOUT_EN
         rsp_err       <= 1'b0;
         to_cnt        <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  owner <= grant_idx;
                  op    <= op_e'(sel_write);
                  ptr   <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                  if (sel_write) begin
                     write_address <= sel_addr;
                     write_data    <= sel_wdata;
                  end else begin
                     read_address  <= sel_addr;
                  end
`ifdef ARB_TIMEOUT_EN
                  to_cnt <= '0;
`endif
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (done) begin
                  write_address <= '0;
                  write_data    <= '0;
                  read_address  <= '0;
                  rsp_valid     <= NUM_REQ'(1) << owner;
                  rsp_data      <= (fire && op == OP_READ) ? read_data : '0;
`ifdef ARB_TIMEOUT_EN
                  rsp_err       <= abort;
`endif
                  state <= RESP;
               end
`ifdef ARB_TIMEOUT_EN
               else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            RESP: begin
               rsp_valid <= '0;
               rsp_data  <= '0;
`ifdef ARB_TIMEOUT_EN
               rsp_err   <= 1'b0;
`endif
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dut_access_arbiter.sv
// Directed, table-driven bench for dut_access_arbiter (NUM_REQ=2, TIMEOUT=15).
module tb_dut_access_arbiter;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic [1:0] req_valid, req_write, req_wdata, req_ready, rsp_valid;
   logic [5:0] req_addr;
   logic       rsp_data, rsp_err;
   logic [2:0] write_address, read_address;
   logic       write_data, write_en, write_rdy, read_en, read_data, read_rdy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   dut_access_arbiter #(.NUM_REQ(2), .TIMEOUT(15)) dut (
      .CLK           (CLK),
      .RST_N         (RST_N),
      .req_valid     (req_valid),
      .req_write     (req_write),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_ready     (req_ready),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .rsp_err       (rsp_err),
      .write_address (write_address),
      .write_data    (write_data),
      .write_en      (write_en),
      .write_rdy     (write_rdy),
      .read_address  (read_address),
      .read_en       (read_en),
      .read_data     (read_data),
      .read_rdy      (read_rdy)
   );

   typedef struct {
      logic [1:0] valid;
      logic [1:0] write;
      logic [1:0] wdata;
      logic [5:0] addr;
      logic       rdata;
      logic [1:0] exp_grant;
      logic       exp_wen;
      logic       exp_ren;
      logic [2:0] exp_waddr;
      logic [2:0] exp_raddr;
      logic       exp_wdata;
      logic       exp_rsp_data;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_req_ready"}, 8'(req_ready), 8'(0));
      chk({nm, "_rsp_valid"}, 8'(rsp_valid), 8'(0));
      chk({nm, "_rsp_data"},  8'(rsp_data),  8'(0));
      chk({nm, "_rsp_err"},   8'(rsp_err),   8'(0));
      chk({nm, "_waddr"},     8'(write_address), 8'(0));
      chk({nm, "_wdata"},     8'(write_data), 8'(0));
      chk({nm, "_wen"},       8'(write_en),  8'(0));
      chk({nm, "_raddr"},     8'(read_address), 8'(0));
      chk({nm, "_ren"},       8'(read_en),   8'(0));
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      req_valid = '0; req_write = '0; req_wdata = '0; req_addr = '0;
      write_rdy = 1'b0; read_rdy = 1'b0; read_data = 1'b0;
      RST_N = 1'b0;
      repeat (2) next_cycle();
      @(negedge CLK);
      chk_idle("in_reset");
      next_cycle();
      RST_N = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      logic [1:0] g;
      //             valid  write  wdata  addr{r1,r0}     rd    grant  wen  ren  waddr raddr wd   rsp
      tbl[0] = '{2'b01, 2'b01, 2'b01, {3'd0, 3'd2}, 1'b0, 2'b01, 1'b1, 1'b0, 3'd2, 3'd0, 1'b1, 1'b0};
      tbl[1] = '{2'b10, 2'b00, 2'b00, {3'd3, 3'd0}, 1'b1, 2'b10, 1'b0, 1'b1, 3'd0, 3'd3, 1'b0, 1'b1};
      tbl[2] = '{2'b11, 2'b10, 2'b00, {3'd6, 3'd7}, 1'b1, 2'b01, 1'b0, 1'b1, 3'd0, 3'd7, 1'b0, 1'b1};
      tbl[3] = '{2'b11, 2'b10, 2'b00, {3'd6, 3'd7}, 1'b1, 2'b10, 1'b1, 1'b0, 3'd6, 3'd0, 1'b0, 1'b0};
      tbl[4] = '{2'b10, 2'b00, 2'b00, {3'd5, 3'd1}, 1'b0, 2'b10, 1'b0, 1'b1, 3'd0, 3'd5, 1'b0, 1'b0};
      tbl[5] = '{2'b01, 2'b01, 2'b01, {3'd7, 3'd0}, 1'b1, 2'b01, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0};
      tbl[6] = '{2'b11, 2'b11, 2'b10, {3'd1, 3'd4}, 1'b0, 2'b10, 1'b1, 1'b0, 3'd1, 3'd0, 1'b1, 1'b0};
      tbl[7] = '{2'b11, 2'b00, 2'b00, {3'd2, 3'd4}, 1'b1, 2'b01, 1'b0, 1'b1, 3'd0, 3'd4, 1'b0, 1'b1};

      do_reset();
      for (int c = 0; c < 5; c++) begin
         @(negedge CLK);
         chk_idle($sformatf("post_reset%0d", c));
         next_cycle();
      end

      // Single transactions; requester inputs are scrambled right after accept
      for (int k = 0; k < 8; k++) begin
         v = tbl[k];
         req_valid = v.valid; req_write = v.write; req_wdata = v.wdata; req_addr = v.addr;
         write_rdy = 1'b1; read_rdy = 1'b1; read_data = 1'b0;
         @(negedge CLK);
         chk($sformatf("v%0d_ready", k), 8'(req_ready), 8'(v.exp_grant));
         next_cycle();
         req_write = ~v.write; req_addr = ~v.addr; req_wdata = ~v.wdata; read_data = v.rdata;
         @(negedge CLK);
         chk($sformatf("v%0d_wen", k),   8'(write_en),      8'(v.exp_wen));
         chk($sformatf("v%0d_ren", k),   8'(read_en),       8'(v.exp_ren));
         chk($sformatf("v%0d_waddr", k), 8'(write_address), 8'(v.exp_waddr));
         chk($sformatf("v%0d_raddr", k), 8'(read_address),  8'(v.exp_raddr));
         chk($sformatf("v%0d_wdata", k), 8'(write_data),    8'(v.exp_wdata));
         chk($sformatf("v%0d_busy_ready", k), 8'(req_ready), 8'(0));
         chk($sformatf("v%0d_early_rsp", k),  8'(rsp_valid), 8'(0));
         next_cycle();
         read_data = 1'b0;
         @(negedge CLK);
         chk($sformatf("v%0d_rsp_valid", k), 8'(rsp_valid), 8'(v.exp_grant));
         chk($sformatf("v%0d_rsp_data", k),  8'(rsp_data),  8'(v.exp_rsp_data));
         chk($sformatf("v%0d_rsp_err", k),   8'(rsp_err),   8'(0));
         chk($sformatf("v%0d_resp_en", k),   8'({write_en, read_en}), 8'(0));
         chk($sformatf("v%0d_resp_ready", k), 8'(req_ready), 8'(0));
         next_cycle();
      end

      // Fairness: both requesters valid continuously, grants alternate every 3 cycles
      do_reset();
      req_valid = 2'b11; req_write = 2'b00; req_addr = {3'd1, 3'd0};
      write_rdy = 1'b1; read_rdy = 1'b1;
      for (int c = 0; c < 12; c++) begin
         g = (((c / 3) % 2) == 0) ? 2'b01 : 2'b10;
         @(negedge CLK);
         chk($sformatf("rr%0d_ready", c), 8'(req_ready), 8'((c % 3 == 0) ? g : 2'b00));
         chk($sformatf("rr%0d_rsp", c),   8'(rsp_valid), 8'((c % 3 == 2) ? g : 2'b00));
         next_cycle();
      end

      // Write stalled on write_rdy for 6 ISSUE cycles
      req_valid = 2'b01; req_write = 2'b01; req_wdata = 2'b01; req_addr = {3'd0, 3'd2};
      write_rdy = 1'b0;
      @(negedge CLK);
      chk("stall_ready", 8'(req_ready), 8'(2'b01));
      next_cycle();
      req_valid = 2'b00;
      for (int c = 0; c < 6; c++) begin
         @(negedge CLK);
         chk($sformatf("stall%0d_wen", c), 8'(write_en),  8'(0));
         chk($sformatf("stall%0d_rsp", c), 8'(rsp_valid), 8'(0));
         next_cycle();
      end
      write_rdy = 1'b1;
      @(negedge CLK);
      chk("stall_wen",   8'(write_en),      8'(1));
      chk("stall_waddr", 8'(write_address), 8'(2));
      chk("stall_wdata", 8'(write_data),    8'(1));
      next_cycle();
      @(negedge CLK);
      chk("stall_rsp_valid", 8'(rsp_valid), 8'(2'b01));
      chk("stall_rsp_err",   8'(rsp_err),   8'(0));
      chk("stall_rsp_data",  8'(rsp_data),  8'(0));
      next_cycle();

`ifdef ARB_TIMEOUT_EN
      // read_rdy stuck low: abort after 15 ISSUE cycles
      req_valid = 2'b10; req_write = 2'b00; req_addr = {3'd3, 3'd0};
      read_rdy = 1'b0; read_data = 1'b1;
      @(negedge CLK);
      chk("to_ready", 8'(req_ready), 8'(2'b10));
      next_cycle();
      req_valid = 2'b00;
      for (int c = 0; c < 15; c++) begin
         @(negedge CLK);
         chk($sformatf("to%0d_ren", c), 8'(read_en),   8'(0));
         chk($sformatf("to%0d_rsp", c), 8'(rsp_valid), 8'(0));
         next_cycle();
      end
      @(negedge CLK);
      chk("to_rsp_valid", 8'(rsp_valid), 8'(2'b10));
      chk("to_rsp_err",   8'(rsp_err),   8'(1));
      chk("to_rsp_data",  8'(rsp_data),  8'(0));
      next_cycle();
      read_data = 1'b0;
`endif

      // Async reset in the middle of ISSUE discards the transaction
      req_valid = 2'b01; req_write = 2'b00; req_addr = {3'd0, 3'd5};
      read_rdy = 1'b0;
      @(negedge CLK);
      chk("mid_rst_ready", 8'(req_ready), 8'(2'b01));
      next_cycle();
      req_valid = 2'b00;
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK);
         chk($sformatf("mid_rst%0d_ren", c), 8'(read_en), 8'(0));
         next_cycle();
      end
      read_rdy = 1'b1;
      #1;
      chk("mid_rst_ren_before", 8'(read_en),      8'(1));
      chk("mid_rst_raddr",      8'(read_address), 8'(5));
      RST_N = 1'b0;
      #1;
      chk("mid_rst_ren_after",   8'(read_en),      8'(0));
      chk("mid_rst_raddr_after", 8'(read_address), 8'(0));
      next_cycle();
      RST_N = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         chk($sformatf("mid_rst%0d_no_rsp", c), 8'(rsp_valid), 8'(0));
         chk($sformatf("mid_rst%0d_idle_en", c), 8'({write_en, read_en}), 8'(0));
         next_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
